// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle unsigned subtractor a - b - bin, CHUNK_WIDTH bits per enabled cycle, LSB chunk first; o_valid rises NCHUNK+1 enabled edges after acceptance
// and the result is held in DONE until i_ready. Optional signed-overflow flag o_ovf is enabled by defining SUB_SIGNED_OVF_EN.
module chunked_borrow_subtractor #(
   parameter int DATA_WIDTH  = 16,
   parameter int CHUNK_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] iv_a,
   input  logic [DATA_WIDTH-1:0] iv_b,
   input  logic                  i_bin,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] ov_diff,
   output logic                  o_bout
`ifdef SUB_SIGNED_OVF_EN
   ,
   output logic                  o_ovf
`endif
);

   localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
   localparam int CNT_W  = $clog2(NCHUNK);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic                    borrow;
   logic [DATA_WIDTH-1:0]   a_q, b_q, diff_q;
   logic                    bout_q;
   logic [CHUNK_WIDTH-1:0]  a_k, b_k;
   logic [CHUNK_WIDTH:0]    diff_k;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  state <= IDLE;
      else if (i_en) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_valid)     state_nxt = BUSY;
         BUSY:    if (cnt == LAST) state_nxt = DONE;
         DONE:    if (i_ready)     state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // The extra top bit of diff_k is the borrow out of this chunk.
   assign a_k    = a_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign b_k    = b_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign diff_k = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK_WIDTH{1'b0}}, borrow};

`ifdef SUB_SIGNED_OVF_EN
   logic ovf_q;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt    <= '0;
         borrow <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else if (i_en) begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_q    <= iv_a;
                  b_q    <= iv_b;
                  borrow <= i_bin;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               diff_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] <= diff_k[CHUNK_WIDTH-1:0];
               borrow <= diff_k[CHUNK_WIDTH];
               if (cnt == LAST) begin
                  cnt    <= '0;
                  bout_q <= diff_k[CHUNK_WIDTH];
`ifdef SUB_SIGNED_OVF_EN
                  // Final chunk MSB is the result sign bit.
                  ovf_q  <= (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                            (diff_k[CHUNK_WIDTH-1] != a_q[DATA_WIDTH-1]);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);
   assign ov_diff = diff_q;
   assign o_bout  = bout_q;
`ifdef SUB_SIGNED_OVF_EN
   assign o_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// Randomized bench for chunked_borrow_subtractor against an arithmetic reference model; o_ovf is checked when SUB_SIGNED_OVF_EN is defined.
module tb_chunked_borrow_subtractor;

   localparam int NCH = 4;

   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, valid = 1'b0, rdy = 1'b0, bin = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        o_ready, o_valid, o_bout;
   logic [15:0] ov_diff;
`ifdef SUB_SIGNED_OVF_EN
   logic        o_ovf;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: result is plain 17-bit arithmetic; visible NCH+1 enabled edges after acceptance.
   bit          m_idle = 1'b1, m_done = 1'b0;
   int          m_wait = 0;
   logic [15:0] m_diff = '0;
   logic        m_bout = 1'b0, m_ovf = 1'b0;

   chunked_borrow_subtractor #(.DATA_WIDTH(16), .CHUNK_WIDTH(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .o_ready(o_ready),
      .iv_a(a), .iv_b(b), .i_bin(bin), .o_valid(o_valid), .i_ready(rdy),
      .ov_diff(ov_diff), .o_bout(o_bout)
`ifdef SUB_SIGNED_OVF_EN
      , .o_ovf(o_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle = 1'b1;
         m_done = 1'b0;
         m_wait = 0;
      end else if (en) begin
         if (m_idle) begin
            if (valid) begin
               {m_bout, m_diff} = {1'b0, a} - {1'b0, b} - 17'(bin);
               m_ovf  = (a[15] != b[15]) && (m_diff[15] != a[15]);
               m_idle = 1'b0;
               m_wait = NCH;
            end
         end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_done = 1'b1;
         end else if (m_done && rdy) begin
            m_done = 1'b0;
            m_idle = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("cmp_ready", o_ready, m_idle);
      chk("cmp_valid", o_valid, m_done);
      if (m_done) begin
         chk("cmp_diff", ov_diff, m_diff);
         chk("cmp_bout", o_bout, m_bout);
`ifdef SUB_SIGNED_OVF_EN
         chk("cmp_ovf", o_ovf, m_ovf);
`endif
      end
   end

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input logic [15:0] ed, input logic eb, input logic eo,
                        input int freeze_at, input int hold);
      int          lat, n;
      logic [15:0] snap;
      n = 0;
      while (!o_ready && n < 20) begin step; n++; end
      chk("wait_ready", o_ready, 1);
      a = ta; b = tb_v; bin = tbin; valid = 1'b1;
      step;
      valid = 1'b0; lat = 1;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      while (!o_valid && lat < 40) begin
         if (lat == freeze_at) begin
            en = 1'b0;
            snap = ov_diff;
            repeat (3) step;
            lat += 3;
            chk("freeze_diff", ov_diff, snap);
            en = 1'b1;
         end else begin
            step;
            lat++;
         end
      end
      chk("latency", lat, (freeze_at > 0) ? NCH + 4 : NCH + 1);
      chk("lit_diff", ov_diff, ed);
      chk("lit_bout", o_bout, eb);
      chk("model_diff", m_diff, ed);
      chk("model_bout", m_bout, eb);
`ifdef SUB_SIGNED_OVF_EN
      chk("lit_ovf", o_ovf, eo);
`else
      if (eo) chk("model_ovf_off", m_ovf, eo);
`endif
      valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         step;
         chk("hold_no_accept", o_ready, 0);
         chk("hold_diff", ov_diff, ed);
         chk("hold_bout", o_bout, eb);
      end
      valid = 1'b0;
      rdy = 1'b1;
      step;
      rdy = 1'b0;
      chk("release_ready", o_ready, 1);
      chk("release_valid", o_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb, rd;
      logic        rbin, rbo, ro;
      #12 rst_n = 1'b1;
      en = 1'b1;
      repeat (3) step;
      chk("rst_ready", o_ready, 1);
      chk("rst_valid", o_valid, 0);
      chk("rst_diff", ov_diff, 0);
      chk("rst_bout", o_bout, 0);

      do_op(16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0, 1'b0, 0, 0);
      do_op(16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 1'b0, 0, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0, 0);
      do_op(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 0);
      do_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 0);
      do_op(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 0);
      do_op(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 0);
      do_op(16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0, 0, 10);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 2, 0);

      // Abort mid-operation: reset lands between edges while chunk 2 is pending.
      a = 16'h7777; b = 16'h0001; bin = 1'b0; valid = 1'b1;
      step;
      valid = 1'b0;
      step;
      step;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", o_ready, 1);
      chk("abort_valid", o_valid, 0);
      chk("abort_diff", ov_diff, 0);
      chk("abort_bout", o_bout, 0);
      repeat (2) step;
      rst_n = 1'b1;
      step;
      do_op(16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         ra   = 16'($urandom);
         rb   = (i % 4 == 0) ? ra : 16'($urandom);
         rbin = 1'($urandom_range(0, 1));
         {rbo, rd} = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
         ro = (ra[15] != rb[15]) && (rd[15] != ra[15]);
         do_op(ra, rb, rbin, rd, rbo, ro,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0,
               int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
